mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 9, the word address width of the shared RAM.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, the data width; byte-enable width = DATA_WIDTH/8.
REQ-003 SHALL have parameter STARVE_LIMIT, default 4, the consecutive denied-fetch cycles before fetch is promoted.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 ld_req, ld_we  input  1  loader port request and write strobe.
REQ-007 ld_addr  input  ADDR_WIDTH; ld_wdata  input  DATA_WIDTH; ld_be  input  DATA_WIDTH/8  loader address, write data, byte enables.
REQ-008 ld_start, ld_done  input  1  single-cycle pulses opening and closing a load session.
REQ-009 d_req, d_we  input  1; d_addr  input  ADDR_WIDTH; d_wdata  input  DATA_WIDTH; d_be  input  DATA_WIDTH/8  CPU data port.
REQ-010 i_req  input  1; i_addr  input  ADDR_WIDTH  CPU fetch port, read-only.
REQ-011 ld_gnt, d_gnt, i_gnt  output  1  combinational same-cycle grant per port.
REQ-012 ld_rvalid, d_rvalid, i_rvalid  output  1  read-data valid per port.
REQ-013 rdata  output  DATA_WIDTH  read data shared by all ports, qualified by the relevant rvalid.
REQ-014 cpu_hold  output  1  high while a load session is active.
REQ-015 mem_en  output  1; mem_we  output  DATA_WIDTH/8; mem_addr  output  ADDR_WIDTH; mem_wdata  output  DATA_WIDTH  RAM control.
REQ-016 mem_rdata  input  DATA_WIDTH  synchronous RAM read data, valid the cycle after mem_en with mem_we==0.

Function
REQ-017 SHALL implement a two-state FSM, RUN and LOAD: RUN->LOAD on ld_start; LOAD->RUN on ld_done; ld_start and ld_done high together leave the state unchanged.
REQ-018 In LOAD: only the loader is served; d_gnt=i_gnt=0; cpu_hold=1.
REQ-019 In RUN: priority ld > d > i; when the starvation counter equals STARVE_LIMIT, priority becomes ld > i > d.
REQ-020 At most one grant SHALL be high per cycle; a grant is given only to a port whose req is high.
REQ-021 The granted port SHALL drive the RAM that cycle: mem_en=1, mem_addr=port addr, mem_wdata=port wdata, mem_we=be when we=1, else 0; with no grant, mem_en=0 and mem_we=0.
REQ-022 A granted read (we=0) SHALL assert that port's rvalid exactly one cycle later, with rdata=mem_rdata; the owner is recorded in a register at grant.
REQ-023 A granted write SHALL produce no rvalid; a write with be=0 is granted and consumes the slot with mem_we=0.
REQ-024 Back-to-back reads from any mix of ports SHALL sustain one grant per cycle, with responses returned in grant order.
REQ-025 Starvation counter: in RUN, it increments (saturating at STARVE_LIMIT) on cycles where i_req=1 and i_gnt=0; it clears on i_gnt=1 or i_req=0; it holds in LOAD.
REQ-026 A read granted in the cycle of a RUN<->LOAD transition SHALL still return its rvalid on the following cycle.
REQ-027 Out-of-range behaviour is not applicable; addresses wrap naturally at ADDR_WIDTH bits.

Reset
REQ-028 While reset=0: state=RUN, starvation counter=0, all gnt and rvalid=0, cpu_hold=0, mem_en=0, mem_we=0.
REQ-029 An asserted reset SHALL cancel any pending rvalid, including one due in the cycle following deassertion.
REQ-030 Outputs SHALL be free of X after reset while inputs are known.

Verification
REQ-031 Fetch-only: i_req=1, i_addr=0..3 consecutive cycles, RAM preloaded with 0x20010001.. -> i_gnt=1 every cycle; i_rvalid from the next cycle onward, with rdata=word[addr].
REQ-032 Conflict: d_req and i_req held high, d_we=0, STARVE_LIMIT=4 -> d granted 4 cycles, i granted cycle 5, counter cleared, d granted cycle 6.
REQ-033 Load session: ld_start, 512 writes of ld_wdata=addr, ld_be=0xF, ld_done; CPU requests meanwhile -> cpu_hold=1 throughout, d_gnt=i_gnt=0; then i reads addr 0x1FF -> 0x000001FF.
REQ-034 Byte write: d_we=1, d_be=0x2, d_wdata=0xAABBCCDD to addr 5 holding 0x11223344; read back -> 0x1122CC44; a be=0 write -> mem_we=0, word unchanged.
REQ-035 Reset mid-read: d read granted, reset asserted before the next edge -> d_rvalid stays 0; state RUN and counter 0 after release.
REQ-036 Random mix of three requesters for 10k cycles against a reference model -> one grant per cycle maximum, every read returned once in order, no fetch wait exceeding STARVE_LIMIT+1 cycles in RUN.

Source files
------------

// File: rtl/mem_arbiter.sv
// Three-port arbiter (loader, CPU data, CPU fetch) in front of a single-port synchronous RAM.
// A load session locks out the CPU; fetch is promoted over data after STARVE_LIMIT denied cycles.
module mem_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 9,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ld_req,
  input  logic                    ld_we,
  input  logic [ADDR_WIDTH-1:0]   ld_addr,
  input  logic [DATA_WIDTH-1:0]   ld_wdata,
  input  logic [DATA_WIDTH/8-1:0] ld_be,
  input  logic                    ld_start,
  input  logic                    ld_done,
  input  logic                    d_req,
  input  logic                    d_we,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  input  logic [DATA_WIDTH/8-1:0] d_be,
  input  logic                    i_req,
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  output logic                    ld_gnt,
  output logic                    d_gnt,
  output logic                    i_gnt,
  output logic                    ld_rvalid,
  output logic                    d_rvalid,
  output logic                    i_rvalid,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    cpu_hold,
  output logic                    mem_en,
  output logic [DATA_WIDTH/8-1:0] mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);

  localparam int unsigned CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic { RUN, LOAD } state_t;
  typedef enum logic [1:0] { OWN_NONE, OWN_LD, OWN_D, OWN_I } owner_t;

  state_t           state_q, state_d;
  owner_t           owner_q, owner_d;
  logic [CNT_W-1:0] starve_q, starve_d;

  // Grants are gated by reset so nothing reaches the RAM while reset is held.
  always_comb begin
    ld_gnt = 1'b0;
    d_gnt  = 1'b0;
    i_gnt  = 1'b0;
    if (reset) begin
      ld_gnt = ld_req;
      if (state_q == RUN && !ld_req) begin
        if (starve_q == LIMIT) begin
          i_gnt = i_req;
          d_gnt = d_req & ~i_req;
        end else begin
          d_gnt = d_req;
          i_gnt = i_req & ~d_req;
        end
      end
    end
  end

  always_comb begin
    mem_en    = ld_gnt | d_gnt | i_gnt;
    mem_we    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    owner_d   = OWN_NONE;
    if (ld_gnt) begin
      mem_addr  = ld_addr;
      mem_wdata = ld_wdata;
      if (ld_we) mem_we  = ld_be;
      else       owner_d = OWN_LD;
    end else if (d_gnt) begin
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
      if (d_we) mem_we  = d_be;
      else      owner_d = OWN_D;
    end else if (i_gnt) begin
      mem_addr = i_addr;
      owner_d  = OWN_I;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (ld_start && !ld_done) state_d = LOAD;
      LOAD:    if (ld_done && !ld_start) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    starve_d = starve_q;
    if (state_q == RUN) begin
      if (i_req && !i_gnt) begin
        if (starve_q != LIMIT) starve_d = starve_q + CNT_W'(1);
      end else begin
        starve_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= RUN;
      owner_q  <= OWN_NONE;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      starve_q <= starve_d;
    end
  end

  assign ld_rvalid = (owner_q == OWN_LD);
  assign d_rvalid  = (owner_q == OWN_D);
  assign i_rvalid  = (owner_q == OWN_I);
  assign rdata     = mem_rdata;
  assign cpu_hold  = (state_q == LOAD);

endmodule
